rv_ctrl_fsm: RTL and testbench
==============================

// Module: rv_ctrl_fsm
// PURPOSE
// - Multi-cycle control unit that drives the register-file/ALU datapath from the opposite end of its control interface.
// - Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes R-type and BEQ/BNE.
// - Sequences reg addresses, alu_control and regwrite into the datapath. Consumes zero_flag back from the datapath for branches.
// - Maintains the PC and a retired-instruction counter.
// PARAMETERS
// - PC_W       32          width of pc output
// - RESET_PC   32'h0       pc value after reset
// - CNT_W      16          width of retired counter
// PORTS
// - clock          in   1      system clock, rising edge
// - reset          in   1      asynchronous, active-low reset
// - instr_valid    in   1      instruction word on instr is valid
// - instr          in   32     RV32I instruction word
// - instr_ready    out  1      FSM can accept an instruction (IDLE only)
// - zero_flag      in   1      datapath ALU result == 0
// - read_reg_num1  out  5      rs1 to datapath
// - read_reg_num2  out  5      rs2 to datapath
// - write_reg      out  5      rd to datapath
// - alu_control    out  4      ALU opcode to datapath
// - regwrite       out  1      register-file write enable
// - pc             out  PC_W   address of current/next instruction
// - retired        out  CNT_W  count of completed instructions, wraps
// - trap           out  1      illegal instruction seen (sticky)
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, pc=RESET_PC, retired=0, trap=0, regwrite=0, alu_control=0, all reg nums=0.
// - Reset applies mid-instruction; a regwrite in flight is dropped.
// - States:
//   - IDLE: instr_ready=1. If instr_valid, capture instr and go to DECODE.
//   - DECODE: drive rs1/rs2/rd from the captured word.
//     - opcode 0110011 with a legal funct7/funct3 pair -> EXEC_R.
//     - opcode 1100011 with funct3 000/001 -> EXEC_B.
//     - Otherwise -> TRAP.
//   - EXEC_R: alu_control valid, regwrite=0 -> WB.
//   - WB: regwrite=1 for exactly 1 cycle, but forced to 0 when rd==0. Then pc+=4, retired+=1 -> IDLE.
//   - EXEC_B: alu_control=SUB; sample zero_flag at the end of the cycle.
//     - Taken (BEQ&zero or BNE&!zero): pc += sign-extended imm_b.
//     - Not taken: pc += 4.
//     - retired+=1, regwrite stays 0 -> IDLE.
//   - TRAP: trap=1, instr_ready=0. Held until reset; pc is not advanced.
// - Latency (handshake cycle excluded): R-type 3 cycles, branch 2 cycles.
// - read_reg_num1/2, write_reg and alu_control are registered and held from DECODE until IDLE.
// - In IDLE, alu_control=0 and regwrite=0.
// - instr is sampled only on instr_valid&&instr_ready; instr_valid is ignored outside IDLE.
// - alu_control map (funct7[5],funct3 -> code):
//   - ADD 0010, SUB 0110, SLL 1000, SLT 0111, SLTU 1011, XOR 0100, SRL 1001, SRA 1010, OR 0001, AND 0000.
//   - Any funct7 other than 0000000 (or 0100000 for SUB/SRA) is illegal.
// - Arithmetic:
//   - pc and imm add modulo 2^PC_W; wrap is silent.
//   - retired wraps from all-ones to 0.
//   - imm_b = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, sign-extended.
// STRUCTURE
// - Shared package rv_pkg:
//   - opcode constants (OP_R, OP_BRANCH);
//   - ALU_* 4-bit codes above;
//   - state enum {IDLE,DECODE,EXEC_R,WB,EXEC_B,TRAP}.
// - One sub-module: rv_alu_dec (combinational funct7/funct3 -> alu_control, illegal).
// - FSM, pc and counter stay in the top module.
// TESTING
// - Reset, then ADD x3,x1,x2 (0x002081B3):
//   - instr_ready drops the cycle after the handshake;
//   - rs1=1, rs2=2, rd=3, alu_control=0010;
//   - regwrite high exactly 1 cycle;
//   - pc=4, retired=1.
// - SUB x5,x1,x2 (0x402082B3) -> alu_control=0110, write_reg=5, one regwrite pulse, pc +=4.
// - BEQ x1,x2,+8 (0x00208463) from pc=8:
//   - zero_flag=1 -> pc=16;
//   - repeat with zero_flag=0 -> pc+=4;
//   - regwrite never asserted.
// - ADD x0,x1,x2 (0x00208033) -> regwrite stays 0, retired still increments.
// - Illegal 0xFFFFFFFF -> trap=1 and instr_ready=0 until reset; pc unchanged.
//   Same for funct7=0x20 with funct3=111.
// - Reset asserted during WB -> regwrite=0 immediately (async), pc=RESET_PC, state IDLE.
//   Next instruction then executes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and state encoding for the RV32I multi-cycle control unit.
package rv_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;

   typedef enum logic [2:0] {IDLE, DECODE, EXEC_R, WB, EXEC_B, TRAP} state_t;
endpackage

// File: rtl/rv_ctrl_fsm_if.sv
// Instruction handshake plus the control/status wires to the register-file/ALU datapath.
interface rv_ctrl_fsm_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        zero_flag;
   logic [4:0]  read_reg_num1;
   logic [4:0]  read_reg_num2;
   logic [4:0]  write_reg;
   logic [3:0]  alu_control;
   logic        regwrite;

   modport master (
      input  instr_valid, instr, zero_flag,
      output instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite
   );
   modport slave (
      output instr_valid, instr, zero_flag,
      input  instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite
   );
endinterface

// File: rtl/rv_alu_dec.sv
// R-type funct7/funct3 to ALU code; flags any encoding outside the supported set.
module rv_alu_dec
   import rv_pkg::*;
(
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output logic [3:0] alu_control,
   output logic       illegal
);
   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      if (funct7 == 7'b0000000) begin
         case (funct3)
            3'b000:  alu_control = ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_AND;
         endcase
      end else if (funct7 == 7'b0100000) begin
         case (funct3)
            3'b000:  alu_control = ALU_SUB;
            3'b101:  alu_control = ALU_SRA;
            default: illegal = 1'b1;
         endcase
      end else begin
         illegal = 1'b1;
      end
   end
endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control unit: R-type and BEQ/BNE sequencing, PC and retired counter.
module rv_ctrl_fsm
   import rv_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic               clock,
   input  logic               reset,
   rv_ctrl_fsm_if.master      bus,
   output logic [PC_W-1:0]    pc,
   output logic [CNT_W-1:0]   retired,
   output logic               trap
);
   state_t            state, state_nx;
   logic [31:0]       ir;
   logic [3:0]        alu_q, alu_nx, dec_alu;
   logic              dec_ill, taken;
   logic [6:0]        dec_f7;
   logic [2:0]        dec_f3;
   logic [12:0]       imm_b;
   logic [PC_W-1:0]   pc_step;

   // One decoder serves both the incoming word (to register alu_control at
   // the handshake) and the captured word (legality check in DECODE).
   assign dec_f7 = (state == IDLE) ? bus.instr[31:25] : ir[31:25];
   assign dec_f3 = (state == IDLE) ? bus.instr[14:12] : ir[14:12];

   rv_alu_dec u_dec (
      .funct7      (dec_f7),
      .funct3      (dec_f3),
      .alu_control (dec_alu),
      .illegal     (dec_ill)
   );

   always_comb begin
      state_nx = state;
      alu_nx   = ALU_AND;
      if (bus.instr[6:0] == OP_BRANCH)
         alu_nx = ALU_SUB;
      else if (bus.instr[6:0] == OP_R && !dec_ill)
         alu_nx = dec_alu;
      imm_b   = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      taken   = ir[12] ? !bus.zero_flag : bus.zero_flag;
      pc_step = PC_W'(4);
      if (state == EXEC_B && taken)
         pc_step = PC_W'($signed(imm_b));
      case (state)
         IDLE:    if (bus.instr_valid) state_nx = DECODE;
         DECODE: begin
            if (ir[6:0] == OP_R && !dec_ill)
               state_nx = EXEC_R;
            else if (ir[6:0] == OP_BRANCH && ir[14:13] == 2'b00)
               state_nx = EXEC_B;
            else
               state_nx = TRAP;
         end
         EXEC_R:  state_nx = WB;
         WB:      state_nx = IDLE;
         EXEC_B:  state_nx = IDLE;
         default: state_nx = TRAP;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ir      <= '0;
         alu_q   <= ALU_AND;
         pc      <= RESET_PC;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.instr_valid) begin
            ir    <= bus.instr;
            alu_q <= alu_nx;
         end
         // Both retiring states hand back to IDLE, where alu_control reads 0.
         if (state == WB || state == EXEC_B) begin
            pc      <= pc + pc_step;
            retired <= retired + CNT_W'(1);
            alu_q   <= ALU_AND;
         end
      end
   end

   assign bus.instr_ready   = (state == IDLE);
   assign bus.read_reg_num1 = ir[19:15];
   assign bus.read_reg_num2 = ir[24:20];
   assign bus.write_reg     = ir[11:7];
   assign bus.alu_control   = alu_q;
   assign bus.regwrite      = (state == WB) && (ir[11:7] != 5'd0);
   assign trap              = (state == TRAP);
endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Bench for rv_ctrl_fsm: instruction-level model checked every cycle plus literal pins.
module tb_rv_ctrl_fsm;
   localparam int          PC_W     = 32;
   localparam int          CNT_W    = 16;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [PC_W-1:0]    pc;
   logic [CNT_W-1:0]   retired;
   logic               trap;

   rv_ctrl_fsm_if bus ();

   rv_ctrl_fsm #(.PC_W(PC_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .pc      (pc),
      .retired (retired),
      .trap    (trap)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_pass = 0;
   int rw_pulses = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- instruction-level model ----------------
   // k counts cycles since the handshake (0 = waiting for an instruction).
   int                 k = 0;
   int                 m_lat = 0;
   bit                 m_trap = 0, m_ill = 0, m_r = 0;
   logic [31:0]        m_ins = '0;
   logic [PC_W-1:0]    m_pc = RESET_PC;
   logic [CNT_W-1:0]   m_ret = '0;

   // {illegal, alu code} from the R-type table
   function automatic logic [4:0] spec_alu(input logic [6:0] f7, input logic [2:0] f3);
      if (f7 == 7'h00) begin
         case (f3)
            3'd0: return {1'b0, 4'b0010};
            3'd1: return {1'b0, 4'b1000};
            3'd2: return {1'b0, 4'b0111};
            3'd3: return {1'b0, 4'b1011};
            3'd4: return {1'b0, 4'b0100};
            3'd5: return {1'b0, 4'b1001};
            3'd6: return {1'b0, 4'b0001};
            default: return {1'b0, 4'b0000};
         endcase
      end
      if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, 4'b0110};
      if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 4'b1010};
      return {1'b1, 4'b0000};
   endfunction

   function automatic bit is_r(input logic [31:0] w);
      return w[6:0] == 7'b0110011;
   endfunction

   function automatic bit is_ill(input logic [31:0] w);
      logic [4:0] d;
      d = spec_alu(w[31:25], w[14:12]);
      if (is_r(w)) return d[4];
      if (w[6:0] == 7'b1100011 && (w[14:12] == 3'd0 || w[14:12] == 3'd1)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [PC_W-1:0] step(input logic [31:0] w, input logic z);
      int  imm;
      bit  tk;
      if (is_r(w)) return PC_W'(4);
      imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      tk  = (w[14:12] == 3'd0) ? z : !z;
      return tk ? PC_W'(imm) : PC_W'(4);
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         k      <= 0;
         m_trap <= 1'b0;
         m_pc   <= RESET_PC;
         m_ret  <= '0;
      end else if (!m_trap) begin
         if (k == 0) begin
            if (bus.instr_valid) begin
               m_ins <= bus.instr;
               m_r   <= is_r(bus.instr);
               m_ill <= is_ill(bus.instr);
               m_lat <= is_r(bus.instr) ? 3 : 2;
               k     <= 1;
            end
         end else if (k == 1 && m_ill) begin
            m_trap <= 1'b1;
            k      <= 0;
         end else if (k == m_lat) begin
            m_pc  <= m_pc + step(m_ins, bus.zero_flag);
            m_ret <= m_ret + CNT_W'(1);
            k     <= 0;
         end else begin
            k <= k + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      logic [4:0] d;
      if (reset) begin
         if (bus.regwrite) rw_pulses <= rw_pulses + 1;
         d = spec_alu(m_ins[31:25], m_ins[14:12]);
         chk("instr_ready", bus.instr_ready, (k == 0) && !m_trap);
         chk("trap", trap, m_trap);
         chk("regwrite", bus.regwrite, m_r && !m_ill && k == 3 && m_ins[11:7] != 5'd0);
         chk("pc", pc, m_pc);
         chk("retired", retired, m_ret);
         if (k >= 1) begin
            chk("rs1", bus.read_reg_num1, m_ins[19:15]);
            chk("rs2", bus.read_reg_num2, m_ins[24:20]);
            chk("rd", bus.write_reg, m_ins[11:7]);
            if (!m_ill) chk("alu_control", bus.alu_control, m_r ? d[3:0] : 4'b0110);
         end else if (!m_trap) begin
            chk("alu_idle", bus.alu_control, 4'b0000);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [31:0] w, input logic z);
      @(negedge clock);
      bus.instr       = w;
      bus.zero_flag   = z;
      bus.instr_valid = 1'b1;
      @(negedge clock);
      bus.instr_valid = 1'b0;
      bus.instr       = 32'hDEAD_BEEF;
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 12; i++) begin
         if (k == 0 && bus.instr_ready) return;
         @(negedge clock);
      end
      n_chk++;
      $display("FAIL %s: timeout waiting for instr_ready", nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.zero_flag   = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_pc", pc, 32'h0);
      chk("rst_retired", retired, 16'h0);
      chk("rst_trap", trap, 1'b0);
      chk("rst_regwrite", bus.regwrite, 1'b0);
      chk("rst_alu", bus.alu_control, 4'b0000);
      chk("rst_rd", bus.write_reg, 5'd0);
      #1 reset = 1'b1;

      // ADD x3,x1,x2
      issue(32'h002081B3, 1'b0);
      chk("add_ready_drop", bus.instr_ready, 1'b0);
      chk("add_rs1", bus.read_reg_num1, 5'd1);
      chk("add_rs2", bus.read_reg_num2, 5'd2);
      chk("add_rd", bus.write_reg, 5'd3);
      chk("add_alu", bus.alu_control, 4'b0010);
      wait_idle("add");
      chk("add_pc", pc, 32'd4);
      chk("add_retired", retired, 16'd1);
      chk("add_pulses", rw_pulses, 1);

      // SUB x5,x1,x2
      issue(32'h402082B3, 1'b0);
      chk("sub_alu", bus.alu_control, 4'b0110);
      chk("sub_rd", bus.write_reg, 5'd5);
      wait_idle("sub");
      chk("sub_pc", pc, 32'd8);
      chk("sub_pulses", rw_pulses, 2);

      // BEQ x1,x2,+8 taken then not taken
      issue(32'h00208463, 1'b1);
      wait_idle("beq_t");
      chk("beq_taken_pc", pc, 32'd16);
      chk("beq_retired", retired, 16'd3);
      issue(32'h00208463, 1'b0);
      wait_idle("beq_nt");
      chk("beq_not_taken_pc", pc, 32'd20);
      chk("beq_pulses", rw_pulses, 2);

      // ADD x0,x1,x2: no write, still retires
      issue(32'h00208033, 1'b0);
      wait_idle("add_x0");
      chk("x0_pc", pc, 32'd24);
      chk("x0_retired", retired, 16'd5);
      chk("x0_pulses", rw_pulses, 2);

      // BNE x1,x2,-4 taken (negative offset)
      issue(32'hFE209EE3, 1'b0);
      wait_idle("bne");
      chk("bne_pc", pc, 32'd20);
      chk("bne_retired", retired, 16'd6);

      // reset during WB
      issue(32'h002081B3, 1'b0);
      for (int i = 0; i < 6 && k != 3; i++) @(negedge clock);
      chk("wb_reached", bus.regwrite, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("rstwb_regwrite", bus.regwrite, 1'b0);
      chk("rstwb_pc", pc, 32'h0);
      chk("rstwb_ready", bus.instr_ready, 1'b1);
      chk("rstwb_retired", retired, 16'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      issue(32'h002081B3, 1'b0);
      wait_idle("post_rst");
      chk("post_rst_pc", pc, 32'd4);
      chk("post_rst_retired", retired, 16'd1);

      // illegal all-ones word
      issue(32'hFFFFFFFF, 1'b0);
      repeat (4) @(negedge clock);
      chk("ill_trap", trap, 1'b1);
      chk("ill_ready", bus.instr_ready, 1'b0);
      chk("ill_pc", pc, 32'd4);

      #2 reset = 1'b0;
      @(negedge clock);
      chk("trap_clr", trap, 1'b0);
      #2 reset = 1'b1;

      // funct7=0x20 with funct3=111
      issue(32'h4020F1B3, 1'b0);
      repeat (4) @(negedge clock);
      chk("f7_trap", trap, 1'b1);
      chk("f7_ready", bus.instr_ready, 1'b0);
      chk("f7_pc", pc, 32'd0);

      @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
